// File: rtl/jogo_pkg.sv
// Shared state codes, level constants and the output
// decode for the memory-game control unit.
package jogo_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    REGISTRA_NIVEL = 4'h2,
    INICIO_MOSTRA  = 4'h3,
    MOSTRA         = 4'h4,
    APAGA          = 4'h5,
    PROXIMA_MOSTRA = 4'h6,
    FIM_MOSTRA     = 4'h7,
    ESPERA_JOGADA  = 4'h8,
    REGISTRA       = 4'h9,
    COMPARACAO     = 4'hA,
    PROXIMA_JOGADA = 4'hB,
    PROXIMA_RODADA = 4'hC,
    FIM_ACERTOU    = 4'hD,
    FIM_ERROU      = 4'hE,
    FIM_TIMEOUT    = 4'hF
  } estado_t;

  localparam logic NIVEL_FACIL   = 1'b0;
  localparam logic NIVEL_DIFICIL = 1'b1;

  typedef struct packed {
    logic zeraR;
    logic registraR;
    logic zeraC;
    logic contaC;
    logic registraN;
    logic zeraCR;
    logic contaCR;
    logic zeraTM;
    logic contaTM;
    logic zeraTempo;
    logic contaTempo;
    logic ativaLedsMem;
    logic ativaLedsJog;
    logic toca;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } ctrl_t;

  function automatic ctrl_t decodifica(estado_t e);
    ctrl_t c;
    c = '0;
    case (e)
      PREPARACAO: begin
        c.zeraR     = 1'b1;
        c.zeraC     = 1'b1;
        c.zeraCR    = 1'b1;
        c.zeraTM    = 1'b1;
        c.zeraTempo = 1'b1;
      end
      REGISTRA_NIVEL: c.registraN = 1'b1;
      INICIO_MOSTRA: begin
        c.zeraC  = 1'b1;
        c.zeraTM = 1'b1;
      end
      MOSTRA: begin
        c.ativaLedsMem = 1'b1;
        c.contaTM      = 1'b1;
`ifdef BUZZER_EN
        c.toca         = 1'b1;
`endif
      end
      APAGA: c.contaTM = 1'b1;
      PROXIMA_MOSTRA: begin
        c.contaC = 1'b1;
        c.zeraTM = 1'b1;
      end
      FIM_MOSTRA: begin
        c.zeraC     = 1'b1;
        c.zeraTempo = 1'b1;
      end
      ESPERA_JOGADA: c.contaTempo = 1'b1;
      REGISTRA: c.registraR = 1'b1;
      COMPARACAO: begin
        c.ativaLedsJog = 1'b1;
`ifdef BUZZER_EN
        c.toca         = 1'b1;
`endif
      end
      PROXIMA_JOGADA: begin
        c.contaC    = 1'b1;
        c.zeraTempo = 1'b1;
      end
      PROXIMA_RODADA: c.contaCR = 1'b1;
      FIM_ACERTOU: begin
        c.pronto  = 1'b1;
        c.acertou = 1'b1;
      end
      FIM_ERROU: begin
        c.pronto = 1'b1;
        c.errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        c.pronto  = 1'b1;
        c.timeout = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seletor_nivel.sv
// Maps the latched difficulty levels onto the round
// and move-time limits used by the control unit.
module seletor_nivel
  import jogo_pkg::*;
(
  input  logic nivelJogadas,
  input  logic nivelTempo,
  input  logic meioCR,
  input  logic fimCR,
  input  logic meioTempo,
  input  logic fimTempo,
  output logic limiteRodada,
  output logic limiteTempo
);

  assign limiteRodada =
    (nivelJogadas == NIVEL_DIFICIL) ? fimCR : meioCR;
  assign limiteTempo =
    (nivelTempo == NIVEL_DIFICIL) ? meioTempo : fimTempo;

endmodule

// File: rtl/jogo_unidade_controle.sv
// Moore control unit for the memory game.
// Define BUZZER_EN to drive toca in mostra/comparacao.
module jogo_unidade_controle
  import jogo_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       jogada_correta,
  input  logic       enderecoIgualRodada,
  input  logic       nivel_jogadas_reg,
  input  logic       nivel_tempo_reg,
  input  logic       fimCR,
  input  logic       meioCR,
  input  logic       fimTempo,
  input  logic       meioTempo,
  input  logic       fimTM,
  input  logic       meioTM,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraC,
  output logic       contaC,
  output logic       registraN,
  output logic       zeraCR,
  output logic       contaCR,
  output logic       zeraTM,
  output logic       contaTM,
  output logic       zeraTempo,
  output logic       contaTempo,
  output logic       ativa_leds_mem,
  output logic       ativa_leds_jog,
  output logic       toca,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t estado;
  estado_t prox;
  ctrl_t   ctrl;
  logic    limiteRodada;
  logic    limiteTempo;

  seletor_nivel uSel (
    .nivelJogadas (nivel_jogadas_reg),
    .nivelTempo   (nivel_tempo_reg),
    .meioCR       (meioCR),
    .fimCR        (fimCR),
    .meioTempo    (meioTempo),
    .fimTempo     (fimTempo),
    .limiteRodada (limiteRodada),
    .limiteTempo  (limiteTempo)
  );

  always_comb begin
    prox = estado;
    unique case (estado)
      INICIAL:
        if (iniciar) prox = PREPARACAO;
      PREPARACAO:     prox = REGISTRA_NIVEL;
      REGISTRA_NIVEL: prox = INICIO_MOSTRA;
      INICIO_MOSTRA:  prox = MOSTRA;
      MOSTRA:
        if (meioTM) prox = APAGA;
      APAGA:
        if (fimTM)
          prox = enderecoIgualRodada ?
                 FIM_MOSTRA : PROXIMA_MOSTRA;
      PROXIMA_MOSTRA: prox = MOSTRA;
      FIM_MOSTRA:     prox = ESPERA_JOGADA;
      // a move beats a timeout landing on the same edge
      ESPERA_JOGADA:
        if (jogada_feita)     prox = REGISTRA;
        else if (limiteTempo) prox = FIM_TIMEOUT;
      REGISTRA:       prox = COMPARACAO;
      COMPARACAO:
        if (!jogada_correta)          prox = FIM_ERROU;
        else if (!enderecoIgualRodada) prox = PROXIMA_JOGADA;
        else if (limiteRodada)        prox = FIM_ACERTOU;
        else                          prox = PROXIMA_RODADA;
      PROXIMA_JOGADA: prox = ESPERA_JOGADA;
      PROXIMA_RODADA: prox = INICIO_MOSTRA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
        if (iniciar) prox = PREPARACAO;
      default:        prox = INICIAL;
    endcase
  end

  // outputs are registered from the next-state decode
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
      ctrl   <= '0;
    end else begin
      estado <= prox;
      ctrl   <= decodifica(prox);
    end
  end

  assign zeraR          = ctrl.zeraR;
  assign registraR      = ctrl.registraR;
  assign zeraC          = ctrl.zeraC;
  assign contaC         = ctrl.contaC;
  assign registraN      = ctrl.registraN;
  assign zeraCR         = ctrl.zeraCR;
  assign contaCR        = ctrl.contaCR;
  assign zeraTM         = ctrl.zeraTM;
  assign contaTM        = ctrl.contaTM;
  assign zeraTempo      = ctrl.zeraTempo;
  assign contaTempo     = ctrl.contaTempo;
  assign ativa_leds_mem = ctrl.ativaLedsMem;
  assign ativa_leds_jog = ctrl.ativaLedsJog;
  assign toca           = ctrl.toca;
  assign pronto         = ctrl.pronto;
  assign acertou        = ctrl.acertou;
  assign errou          = ctrl.errou;
  assign timeout        = ctrl.timeout;
  assign db_estado      = estado;

endmodule

// File: tb/tb_jogo_unidade_controle.sv
// Directed bench for jogo_unidade_controle: expected
// states are queued per step and checked after each edge.
module tb_jogo_unidade_controle;

  logic clock = 1'b0;
  logic reset;
  logic iniciar, jogada_feita, jogada_correta;
  logic enderecoIgualRodada;
  logic nivel_jogadas_reg, nivel_tempo_reg;
  logic fimCR, meioCR, fimTempo, meioTempo;
  logic fimTM, meioTM;
  logic zeraR, registraR, zeraC, contaC, registraN;
  logic zeraCR, contaCR, zeraTM, contaTM;
  logic zeraTempo, contaTempo;
  logic ativa_leds_mem, ativa_leds_jog, toca;
  logic pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;
  int cntCR  = 0;
  logic [3:0] expQ[$];

  always #5 clock = ~clock;

  jogo_unidade_controle dut (
    .clock               (clock),
    .reset               (reset),
    .iniciar             (iniciar),
    .jogada_feita        (jogada_feita),
    .jogada_correta      (jogada_correta),
    .enderecoIgualRodada (enderecoIgualRodada),
    .nivel_jogadas_reg   (nivel_jogadas_reg),
    .nivel_tempo_reg     (nivel_tempo_reg),
    .fimCR               (fimCR),
    .meioCR              (meioCR),
    .fimTempo            (fimTempo),
    .meioTempo           (meioTempo),
    .fimTM               (fimTM),
    .meioTM              (meioTM),
    .zeraR               (zeraR),
    .registraR           (registraR),
    .zeraC               (zeraC),
    .contaC              (contaC),
    .registraN           (registraN),
    .zeraCR              (zeraCR),
    .contaCR             (contaCR),
    .zeraTM              (zeraTM),
    .contaTM             (contaTM),
    .zeraTempo           (zeraTempo),
    .contaTempo          (contaTempo),
    .ativa_leds_mem      (ativa_leds_mem),
    .ativa_leds_jog      (ativa_leds_jog),
    .toca                (toca),
    .pronto              (pronto),
    .acertou             (acertou),
    .errou               (errou),
    .timeout             (timeout),
    .db_estado           (db_estado)
  );

  function automatic logic [17:0] expOut(logic [3:0] s);
    logic zR, rR, zC, cC, rN, zCR, cCR, zTM, cTM;
    logic zT, cT, lm, lj, tc, pr, ac, er, to;
    {zR, rR, zC, cC, rN, zCR, cCR, zTM, cTM} = '0;
    {zT, cT, lm, lj, tc, pr, ac, er, to} = '0;
    case (s)
      4'h1: {zR, zC, zCR, zTM, zT} = 5'b11111;
      4'h2: rN = 1'b1;
      4'h3: {zC, zTM} = 2'b11;
      4'h4: begin
        lm = 1'b1; cTM = 1'b1;
`ifdef BUZZER_EN
        tc = 1'b1;
`endif
      end
      4'h5: cTM = 1'b1;
      4'h6: {cC, zTM} = 2'b11;
      4'h7: {zC, zT} = 2'b11;
      4'h8: cT = 1'b1;
      4'h9: rR = 1'b1;
      4'hA: begin
        lj = 1'b1;
`ifdef BUZZER_EN
        tc = 1'b1;
`endif
      end
      4'hB: {cC, zT} = 2'b11;
      4'hC: cCR = 1'b1;
      4'hD: {pr, ac} = 2'b11;
      4'hE: {pr, er} = 2'b11;
      4'hF: {pr, to} = 2'b11;
      default: ;
    endcase
    return {zR, rR, zC, cC, rN, zCR, cCR, zTM, cTM,
            zT, cT, lm, lj, tc, pr, ac, er, to};
  endfunction

  task automatic clearIn();
    iniciar = 0; jogada_feita = 0; jogada_correta = 0;
    enderecoIgualRodada = 0;
    fimCR = 0; meioCR = 0; fimTempo = 0; meioTempo = 0;
    fimTM = 0; meioTM = 0;
  endtask

  task automatic check(string tag);
    logic [3:0]  e;
    logic [17:0] obs, ex;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: queue empty", tag);
      return;
    end
    e   = expQ.pop_front();
    obs = {zeraR, registraR, zeraC, contaC, registraN,
           zeraCR, contaCR, zeraTM, contaTM, zeraTempo,
           contaTempo, ativa_leds_mem, ativa_leds_jog, toca,
           pronto, acertou, errou, timeout};
    ex  = expOut(e);
    if (contaCR === 1'b1) cntCR++;
    checks++;
    assert (db_estado === e) else begin
      errors++;
      $error("FAIL %s state: got %h want %h", tag, db_estado, e);
    end
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s outs: got %b want %b", tag, obs, ex);
    end
  endtask

  task automatic tick(logic [3:0] e, string tag);
    expQ.push_back(e);
    @(posedge clock);
    #1;
    check(tag);
    clearIn();
  endtask

  task automatic startGame();
    iniciar = 1; tick(4'h1, "start");
    tick(4'h2, "nivel");
    tick(4'h3, "iniMostra");
  endtask

  // from state 3: play round 0 and land in espera_jogada
  task automatic reach8();
    tick(4'h4, "mostra");
    meioTM = 1; tick(4'h5, "apaga");
    fimTM = 1; enderecoIgualRodada = 1; tick(4'h7, "fimMostra");
    tick(4'h8, "espera");
  endtask

  // from state 3: show r+1 items, then r+1 moves
  task automatic rodada(int r, int wrong);
    tick(4'h4, "mostra");
    for (int i = 0; i <= r; i++) begin
      meioTM = 1; tick(4'h5, "apaga");
      fimTM = 1;
      enderecoIgualRodada = (i == r);
      tick((i == r) ? 4'h7 : 4'h6, "fimItem");
      if (i < r) tick(4'h4, "proxMostra");
    end
    tick(4'h8, "espera");
    for (int m = 0; m <= r; m++) begin
      jogada_feita = 1; tick(4'h9, "registra");
      tick(4'hA, "comparacao");
      jogada_correta = (m != wrong);
      enderecoIgualRodada = (m == r);
      meioCR = (r == 7);
      if (m == wrong) begin
        tick(4'hE, "errou");
        return;
      end
      if (m < r) begin
        tick(4'hB, "proxJogada");
        tick(4'h8, "espera2");
      end else if (r == 7) begin
        tick(4'hD, "acertou");
      end else begin
        tick(4'hC, "proxRodada");
        tick(4'h3, "iniMostra2");
      end
    end
  endtask

  initial begin
    clearIn();
    nivel_jogadas_reg = 0;
    nivel_tempo_reg = 0;
    reset = 0;
    #12;
    expQ.push_back(4'h0);
    check("reset");
    reset = 1;
    tick(4'h0, "idle");

    startGame();
    tick(4'h4, "mostra0");
    #2;
    reset = 0;
    expQ.push_back(4'h0);
    #1;
    check("asyncReset");
    reset = 1;
    startGame();
    tick(4'h4, "mostraR");
    meioTM = 1; tick(4'h5, "apagaR");
    fimTM = 1; enderecoIgualRodada = 1; tick(4'h7, "fimR");
    tick(4'h8, "esperaR");
    jogada_feita = 1; tick(4'h9, "regR");
    tick(4'hA, "cmpR");
    jogada_correta = 0; tick(4'hE, "errR");

    iniciar = 1; tick(4'h1, "restart");
    tick(4'h2, "nivel");
    tick(4'h3, "iniMostra");
    cntCR = 0;
    for (int r = 0; r < 8; r++) rodada(r, -1);
    checks++;
    assert (cntCR == 7) else begin
      errors++;
      $error("FAIL contaCR count: got %0d want 7", cntCR);
    end
    tick(4'hD, "holdD");

    startGame();
    rodada(0, -1);
    rodada(1, -1);
    rodada(2, 1);
    tick(4'hE, "holdE");

    nivel_tempo_reg = 1;
    startGame();
    reach8();
    meioTempo = 1; tick(4'hF, "toDificil");
    tick(4'hF, "holdF");

    nivel_tempo_reg = 0;
    startGame();
    reach8();
    meioTempo = 1; tick(4'h8, "meioFacil");
    tick(4'h8, "esperaFacil");
    fimTempo = 1; tick(4'hF, "toFacil");

    startGame();
    reach8();
    jogada_feita = 1; fimTempo = 1;
    tick(4'h9, "prioridade");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jogo_unidade_controle.md
# jogo_unidade_controle

Moore FSM that sequences the memory-game datapath. It does three things: latches the difficulty level, plays back the stored sequence one round at a time, then times and checks each player move. It drives every control input of the datapath, consumes its condition outputs, and reports the game outcome to the top level.

## Interface
Parameters:
- none (all timing comes from datapath counters)

Ports:
- clock  input  1  system clock; all state changes occur on the rising edge
- reset  input  1  asynchronous, active-low; 0 forces state inicial immediately
- iniciar  input  1  start/restart request, level-sampled
- jogada_feita, jogada_correta, enderecoIgualRodada  input  1 each  datapath conditions
- nivel_jogadas_reg, nivel_tempo_reg  input  1 each  latched levels
- fimCR, meioCR, fimTempo, meioTempo, fimTM, meioTM  input  1 each  counter conditions
- zeraR, registraR, zeraC, contaC, registraN, zeraCR, contaCR, zeraTM, contaTM, zeraTempo, contaTempo  output  1 each  datapath controls
- ativa_leds_mem, ativa_leds_jog, toca  output  1 each  LED/buzzer controls
- pronto, acertou, errou, timeout  output  1 each  outcome flags
- db_estado  output  4  current state code

## Operation
- Outputs are pure decodes of the state register. Every output is 0 unless it is listed for the current state.
- States and codes, with the outputs asserted in each and the next state:
  - 0 inicial: no outputs. If iniciar=1 → 1.
  - 1 preparacao: zeraR, zeraC, zeraCR, zeraTM, zeraTempo. Always → 2.
  - 2 registra_nivel: registraN. Always → 3.
  - 3 inicio_mostra: zeraC, zeraTM. Always → 4.
  - 4 mostra: ativa_leds_mem, contaTM, toca*. If meioTM=1 → 5.
  - 5 apaga: contaTM. If fimTM=1: go to 7 when enderecoIgualRodada=1, otherwise → 6.
  - 6 proxima_mostra: contaC, zeraTM. Always → 4.
  - 7 fim_mostra: zeraC, zeraTempo. Always → 8.
  - 8 espera_jogada: contaTempo. If jogada_feita=1 → 9. Otherwise, if limite_tempo=1 → F.
  - 9 registra: registraR. Always → A.
  - A comparacao: ativa_leds_jog, toca*. Transitions:
    - jogada_correta=0 → E.
    - enderecoIgualRodada=0 → B.
    - limite_rodada=1 → D.
    - otherwise → C.
  - B proxima_jogada: contaC, zeraTempo. Always → 8.
  - C proxima_rodada: contaCR. Always → 3.
  - D fim_acertou: pronto, acertou. If iniciar=1 → 1.
  - E fim_errou: pronto, errou. If iniciar=1 → 1.
  - F fim_timeout: pronto, timeout. If iniciar=1 → 1.
- Level selection:
  - limite_tempo = nivel_tempo_reg ? meioTempo : fimTempo (level 1 gives half the timeout).
  - limite_rodada = nivel_jogadas_reg ? fimCR : meioCR (level 0 is 8 rounds, level 1 is 16).
- iniciar is ignored in every state except 0, D, E and F.

## Timing
- Reset value: state 0 and db_estado=0. All outputs are therefore 0.
- iniciar sampled at clock edge k puts the FSM in preparacao at k. registra_nivel follows at k+1 and inicio_mostra at k+2.
- zeraR and registraN are never asserted in the same cycle. This keeps the clear from masking the level capture.
- Each playback item lasts from entry into mostra until fimTM. The LED is on until meioTM and off for the rest.
- Round r (0-based) shows r+1 items, then enters espera_jogada exactly one cycle after fim_mostra.
- In espera_jogada, jogada_feita has priority when it coincides with limite_tempo.
- A move reaches comparacao 2 cycles after the jogada_feita pulse: registra, then comparacao. The ativa_leds_jog feedback lasts one cycle.
- Reset asserted in any state aborts immediately to inicial. There is no partial-state retention.
- An outcome flag holds until a restart. pronto and the flag drop on the cycle the FSM enters preparacao.

## Configuration
- BUZZER_EN defined: toca=1 in mostra and comparacao (the states marked * above).
- BUZZER_EN undefined: toca is tied to 0. The state sequence and all other outputs are identical.

## Structure
- Shared package jogo_pkg holds:
  - the 4-bit state encoding constants (0–F above);
  - the level constants NIVEL_FACIL=1'b0 and NIVEL_DIFICIL=1'b1.
- One combinational sub-module, seletor_nivel. It maps (nivel_jogadas_reg, nivel_tempo_reg, meio*/fim* inputs) to (limite_rodada, limite_tempo).
- Next-state logic and output decode stay in jogo_unidade_controle.

## Test plan
- Reset low mid-mostra (state 4) → db_estado=0 at once, all outputs 0; release and iniciar=1 → db_estado sequence 1,2,3,4.
- Level 0, correct moves on every round → D reached after round 7: acertou=1, pronto=1, and contaCR pulsed exactly 7 times.
- Round 2, move 1 with jogada_correta=0 → A then E: errou=1, and no contaC after the comparison.
- nivel_tempo_reg=1, no move, meioTempo rises → F: timeout=1. With nivel_tempo_reg=0 the same meioTempo keeps the FSM in state 8 until fimTempo.
- jogada_feita and limite_tempo in the same cycle in state 8 → next state 9, not F.
- BUZZER_EN undefined, full level-0 game → toca never 1; the trace is otherwise identical to the BUZZER_EN build.
